route_loop_sequencer: RTL
=========================

ROUTE_LOOP_SEQUENCER -- requirements
Module: route_loop_sequencer

Interface
REQ-001 Parameter NPATH, default 4: number of candidate route paths into the loopback SLICE register, 2..16.
REQ-002 Parameter SETTLE, default 2: cycles between driving a bit and sampling the loopback, 1..15.
REQ-003 Parameter NBITS, default 4: pattern bits per path, alternating 0,1,0,1..., 2..16.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin a sweep; sampled only in IDLE.
REQ-007 q_in  in  1  loopback from SLICE Q0, synchronous to clk.
REQ-008 path_sel  out  clog2(NPATH)  route path currently under test.
REQ-009 drv  out  1  value presented to the SLICE LUT input A0.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at sweep end.
REQ-012 fail_mask  out  NPATH  bit p set if path p had any mismatch in the last sweep.
REQ-013 err_cnt  out  8  total mismatches in the last sweep, saturating at 255.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK, NEXT, DONE.
REQ-015 IDLE: start=1 -> DRIVE; path_sel, bit index and settle counter zeroed; fail_mask and err_cnt cleared in the same cycle.
REQ-016 DRIVE: drv <= bit index[0] (first bit 0); -> SETTLE next cycle with settle counter loaded to SETTLE-1.
REQ-017 SETTLE: counter decrements each cycle; at 0 -> CHECK; drv held stable.
REQ-018 CHECK: if q_in != drv, set fail_mask[path_sel] and increment err_cnt unless already 255; -> NEXT.
REQ-019 NEXT: if bit index < NBITS-1, increment it -> DRIVE; else bit index <= 0 and, if path_sel < NPATH-1, increment path_sel -> DRIVE; else -> DONE.
REQ-020 DONE: done=1 for exactly one cycle -> IDLE; fail_mask and err_cnt hold until next start.
REQ-021 Per-bit latency SHALL be SETTLE+3 cycles; full sweep NPATH*NBITS*(SETTLE+3)+1 cycles from start to done.
REQ-022 start while busy SHALL be ignored; start coincident with DONE SHALL NOT retrigger.
REQ-023 path_sel SHALL NOT change except in NEXT; it SHALL never exceed NPATH-1.

Reset
REQ-024 rst asserted at any time, including mid-sweep, SHALL force IDLE with drv=0, path_sel=0, busy=0, done=0, fail_mask=0, err_cnt=0, counters 0.
REQ-025 Deassertion SHALL take effect on the next rising clk edge without glitching done.

Configuration
REQ-026 Macro ROUTE_LOOP_ABORT_EN, when defined, SHALL add input abort (1 bit): abort=1 in any busy state -> IDLE next cycle, no done pulse, fail_mask/err_cnt keep partial results.
REQ-027 Without ROUTE_LOOP_ABORT_EN the abort port SHALL not exist and a sweep always runs to completion.

Structure
REQ-028 Package route_loop_pkg SHALL hold the FSM state enum, the err_cnt width constant (8) and saturation value (255).
REQ-029 One sub-module, route_loop_settle_cnt (loadable down-counter with zero flag), SHALL implement the settle timer.

Verification
REQ-030 Ideal loopback (q_in=drv delayed 1 cycle), NPATH=4, SETTLE=2 -> done at cycle 81 after start, fail_mask=0000, err_cnt=0.
REQ-031 q_in stuck 0 on path 2 only -> fail_mask=0100, err_cnt=2.
REQ-032 q_in stuck 1 on all paths, NBITS=16, NPATH=16 -> err_cnt=128, fail_mask=FFFF; with NBITS=16 and inverted loopback -> err_cnt saturates at 255 (256 mismatches).
REQ-033 rst asserted in SETTLE of path 1 -> next cycle busy=0, all outputs 0; following start runs a full clean sweep.
REQ-034 start pulsed repeatedly while busy -> exactly one done pulse per sweep.
REQ-035 With ROUTE_LOOP_ABORT_EN, abort during path 3 after a path-0 failure -> IDLE, no done, fail_mask=0001 retained.

Source files
------------

// File: rtl/route_loop_pkg.sv
// Shared definitions for the route loop sequencer.
//   state_t  : sequencer FSM states (IDLE, DRIVE, SETTLE, CHECK, NEXT, DONE)
//   ERR_W    : width of the mismatch counter
//   ERR_SAT  : value at which the mismatch counter stops counting
package route_loop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int             ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

endpackage

// File: rtl/route_loop_settle_cnt.sv
// Settle timer: loadable down-counter with a zero flag.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clr       : force count to 0
//   load      : load load_val (priority below clr)
//   dec       : decrement by one, stops at 0
//   load_val  : value to load
//   zero      : count is 0
module route_loop_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/route_loop_sequencer.sv
// Route loop sequencer: sweeps NPATH candidate route paths, drives an
// alternating 0,1,0,1... pattern of NBITS bits on each, waits SETTLE cycles
// and compares the loopback against the driven value.
// Optional feature macro: ROUTE_LOOP_ABORT_EN adds the abort input.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   start      : begin a sweep (only looked at in IDLE)
//   q_in       : loopback from the slice register
//   abort      : (ROUTE_LOOP_ABORT_EN only) drop back to IDLE, keep results
//   path_sel   : path under test
//   drv        : value presented to the slice LUT input
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at end of sweep
//   fail_mask  : per-path mismatch flags of the last sweep
//   err_cnt    : saturating mismatch count of the last sweep
module route_loop_sequencer
    import route_loop_pkg::*;
#(
    parameter int NPATH  = 4,
    parameter int SETTLE = 2,
    parameter int NBITS  = 4,
    localparam int PW    = (NPATH > 1) ? $clog2(NPATH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             q_in,
`ifdef ROUTE_LOOP_ABORT_EN
    input  logic             abort,
`endif
    output logic [PW-1:0]    path_sel,
    output logic             drv,
    output logic             busy,
    output logic             done,
    output logic [NPATH-1:0] fail_mask,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int BW = $clog2(NBITS);
    localparam int SW = 4;

    state_t           state_reg, state_next;
    logic [PW-1:0]    path_reg, path_next;
    logic [BW-1:0]    bit_reg, bit_next;
    logic             drv_reg, drv_next;
    logic [NPATH-1:0] fail_reg, fail_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic             abort_req;

`ifdef ROUTE_LOOP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    route_loop_settle_cnt #(.W(SW)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (SW'(SETTLE - 1)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            path_reg  <= '0;
            bit_reg   <= '0;
            drv_reg   <= 1'b0;
            fail_reg  <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            path_reg  <= path_next;
            bit_reg   <= bit_next;
            drv_reg   <= drv_next;
            fail_reg  <= fail_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        path_next  = path_reg;
        bit_next   = bit_reg;
        drv_next   = drv_reg;
        fail_next  = fail_reg;
        err_next   = err_reg;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        // Abort leaves the partial fail_mask/err_cnt in place and skips DONE,
        // so no done pulse is produced for an aborted sweep.
        if (abort_req && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            drv_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_DRIVE;
                        path_next  = '0;
                        bit_next   = '0;
                        cnt_clr    = 1'b1;
                        fail_next  = '0;
                        err_next   = '0;
                    end
                end
                ST_DRIVE: begin
                    // Even bit indices drive 0, odd drive 1.
                    drv_next   = bit_reg[0];
                    cnt_load   = 1'b1;
                    state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state_next = ST_CHECK;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (q_in != drv_reg) begin
                        fail_next[path_reg] = 1'b1;
                        if (err_reg != ERR_SAT) begin
                            err_next = err_reg + 1'b1;
                        end
                    end
                    state_next = ST_NEXT;
                end
                ST_NEXT: begin
                    if (bit_reg < BW'(NBITS - 1)) begin
                        bit_next   = bit_reg + 1'b1;
                        state_next = ST_DRIVE;
                    end else begin
                        bit_next = '0;
                        if (path_reg < PW'(NPATH - 1)) begin
                            path_next  = path_reg + 1'b1;
                            state_next = ST_DRIVE;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    drv_next   = 1'b0;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign path_sel  = path_reg;
    assign drv       = drv_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign fail_mask = fail_reg;
    assign err_cnt   = err_reg;

endmodule
